// File: rtl/rrat_pkg.sv
// Shared types and sizing for the retirement RAT: architectural map entry types,
// commit/output bundles and the free-list ring index helper.
package rrat_pkg;

  localparam int SIZE        = 32;
  localparam int FL_SIZE     = 32;
  localparam int N           = 2;
  localparam int PHYS_REG_SZ = SIZE + FL_SIZE;

  localparam int ARN_W    = $clog2(SIZE);
  localparam int PRN_W    = $clog2(PHYS_REG_SZ);
  localparam int FL_IDX_W = $clog2(FL_SIZE);
  localparam int FL_CTR_W = $clog2(FL_SIZE + 1);

  typedef logic [ARN_W-1:0]    arn_t;
  typedef logic [PRN_W-1:0]    prn_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;
  typedef logic [FL_CTR_W-1:0] fl_ctr_t;

  localparam arn_t ZERO_REG = '0;

  typedef struct packed {
    logic valid;
    prn_t prn;
  } free_list_packet_t;

  typedef struct packed {
    logic valid;
    arn_t dest_arn;
    prn_t dest_prn;
  } rrat_ct_entry_t;

  typedef struct packed {
    rrat_ct_entry_t [N-1:0] entries;
    logic                   squash;
  } rrat_ct_input_t;

  typedef struct packed {
    prn_t [SIZE-1:0]             entries;
    free_list_packet_t [N-1:0]   free_packet;
    prn_t [FL_SIZE-1:0]          free_list;
    fl_idx_t                     head;
    fl_idx_t                     tail;
    fl_ctr_t                     free_list_counter;
    logic                        squash;
  } rrat_ct_output_t;

  // Ring index increment that also works when FL_SIZE is not a power of two.
  function automatic fl_idx_t fl_inc(fl_idx_t idx);
    return (idx == fl_idx_t'(FL_SIZE - 1)) ? '0 : idx + fl_idx_t'(1);
  endfunction

endpackage

// File: rtl/rrat_if.sv
// Commit-side bundle between the ROB commit stage and the RRAT, plus the
// snapshot/free-packet bundle returned to the rename RAT.
interface rrat_if;
  import rrat_pkg::*;

  logic [N-1:0]    ct_valid;
  arn_t [N-1:0]    ct_dest_arn;
  prn_t [N-1:0]    ct_dest_prn;
  logic            ct_squash;
  rrat_ct_output_t rrat_ct_output;

  modport master (
    output ct_valid, ct_dest_arn, ct_dest_prn, ct_squash,
    input  rrat_ct_output
  );

  modport slave (
    input  ct_valid, ct_dest_arn, ct_dest_prn, ct_squash,
    output rrat_ct_output
  );

endinterface

// File: rtl/rrat_free_list.sv
// Committed-state free-list ring: up to N pops and N pushes per cycle, applied
// slot by slot (pop before push within a slot), with head/tail/occupancy.
module rrat_free_list
  import rrat_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         pop_en_i,
  input  logic [N-1:0]         push_en_i,
  input  prn_t [N-1:0]         push_prn_i,
  output prn_t [N-1:0]         pop_prn_o,
  output prn_t [FL_SIZE-1:0]   ring_o,
  output fl_idx_t              head_o,
  output fl_idx_t              tail_o,
  output fl_ctr_t              counter_o
);

  prn_t [FL_SIZE-1:0] ring_q, ring_d;
  fl_idx_t            head_q, head_d;
  fl_idx_t            tail_q, tail_d;
  fl_ctr_t            counter_q, counter_d;

  // NOTE: blocking assignments here are intentional; each slot sees the
  // head/tail already advanced by lower-numbered slots in the same cycle.
  always_comb begin
    ring_d    = ring_q;
    head_d    = head_q;
    tail_d    = tail_q;
    counter_d = counter_q;
    pop_prn_o = '0;
    for (int i = 0; i < N; i++) begin
      pop_prn_o[i] = ring_q[head_d];
      if (pop_en_i[i]) begin
        head_d    = fl_inc(head_d);
        counter_d = counter_d - fl_ctr_t'(1);
      end
      if (push_en_i[i]) begin
        ring_d[tail_d] = push_prn_i[i];
        tail_d         = fl_inc(tail_d);
        counter_d      = counter_d + fl_ctr_t'(1);
      end
    end
  end

  // NOTE: the ring is reset entry by entry because its contents are committed
  // architectural state that squash recovery copies straight into the rename RAT.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < FL_SIZE; j++) ring_q[j] <= prn_t'(SIZE + j);
      head_q    <= '0;
      tail_q    <= '0;
      counter_q <= fl_ctr_t'(FL_SIZE);
    end else begin
      ring_q    <= ring_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      counter_q <= counter_d;
    end
  end

  assign ring_o    = ring_q;
  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign counter_o = counter_q;

endmodule

// File: rtl/rrat.sv
// Retirement RAT: architectural ARN->PRN map updated in program order at commit;
// returns freed PRNs and a registered squash-recovery snapshot to the rename RAT.
module rrat
  import rrat_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  rrat_if.slave ct_if
);

  prn_t [SIZE-1:0]           map_q, map_d;
  free_list_packet_t [N-1:0] free_packet_q, free_packet_d;
  logic                      squash_q, squash_d;

  logic [N-1:0]       pop_en, push_en;
  prn_t [N-1:0]       push_prn, pop_prn;
  prn_t [FL_SIZE-1:0] fl_ring;
  fl_idx_t            fl_head, fl_tail;
  fl_ctr_t            fl_counter;

  // In-order commit: a later slot naming the same ARN frees the earlier slot's PRN.
  always_comb begin
    map_d         = map_q;
    free_packet_d = '0;
    pop_en        = '0;
    push_en       = '0;
    push_prn      = '0;
    for (int i = 0; i < N; i++) begin
      if (ct_if.ct_valid[i] && ct_if.ct_dest_arn[i] != ZERO_REG) begin
        push_prn[i]                 = map_d[ct_if.ct_dest_arn[i]];
        map_d[ct_if.ct_dest_arn[i]] = ct_if.ct_dest_prn[i];
        pop_en[i]                   = 1'b1;
        push_en[i]                  = 1'b1;
        free_packet_d[i]            = '{valid: 1'b1, prn: push_prn[i]};
      end
    end
    // Freed PRNs of a squash cycle travel inside the snapshot instead.
    if (ct_if.ct_squash) free_packet_d = '0;
    squash_d = ct_if.ct_squash;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) map_q[i] <= prn_t'(i);
      free_packet_q <= '0;
      squash_q      <= 1'b0;
    end else begin
      map_q         <= map_d;
      free_packet_q <= free_packet_d;
      squash_q      <= squash_d;
    end
  end

  rrat_free_list u_free_list (
    .clock      (clock),
    .reset      (reset),
    .pop_en_i   (pop_en),
    .push_en_i  (push_en),
    .push_prn_i (push_prn),
    .pop_prn_o  (pop_prn),
    .ring_o     (fl_ring),
    .head_o     (fl_head),
    .tail_o     (fl_tail),
    .counter_o  (fl_counter)
  );

  always_comb begin
    ct_if.rrat_ct_output                   = '0;
    ct_if.rrat_ct_output.entries           = map_q;
    ct_if.rrat_ct_output.free_packet       = free_packet_q;
    ct_if.rrat_ct_output.free_list         = fl_ring;
    ct_if.rrat_ct_output.head              = fl_head;
    ct_if.rrat_ct_output.tail              = fl_tail;
    ct_if.rrat_ct_output.free_list_counter = fl_counter;
    ct_if.rrat_ct_output.squash            = squash_q;
  end

  // Pops always match pushes, and the committed PRN must be the one rename took from the ring.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (fl_counter == fl_ctr_t'(FL_SIZE))
        else $warning("rrat: free list counter %0d, expected %0d", fl_counter, FL_SIZE);
      for (int i = 0; i < N; i++) begin
        if (pop_en[i]) begin
          assert (ct_if.ct_dest_prn[i] == pop_prn[i])
            else $warning("rrat: slot %0d dest_prn %0d differs from ring head %0d",
                          i, ct_if.ct_dest_prn[i], pop_prn[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_rrat.sv
// Directed bench for rrat: reset state, single/same-ARN/zero-reg commits,
// squash snapshot, reset priority, sparse valids and ring wrap-around.
module tb_rrat;
  import rrat_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  rrat_if ct_if ();

  rrat dut (
    .clock (clock),
    .reset (reset),
    .ct_if (ct_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ct_if.ct_valid    = '0;
    ct_if.ct_dest_arn = '0;
    ct_if.ct_dest_prn = '0;
    ct_if.ct_squash   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Drive one commit cycle, then sample #1 after the edge with inputs idled.
  task automatic commit(input logic [1:0] vld, input int arn0, input int prn0,
                        input int arn1, input int prn1, input logic sq);
    ct_if.ct_valid       = vld;
    ct_if.ct_dest_arn[0] = arn_t'(arn0);
    ct_if.ct_dest_prn[0] = prn_t'(prn0);
    ct_if.ct_dest_arn[1] = arn_t'(arn1);
    ct_if.ct_dest_prn[1] = prn_t'(prn1);
    ct_if.ct_squash      = sq;
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;

    check("rst_entries5", 64'(ct_if.rrat_ct_output.entries[5]), 64'd5);
    check("rst_entries31", 64'(ct_if.rrat_ct_output.entries[31]), 64'd31);
    check("rst_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd32);
    check("rst_fl31", 64'(ct_if.rrat_ct_output.free_list[31]), 64'd63);
    check("rst_head", 64'(ct_if.rrat_ct_output.head), 64'd0);
    check("rst_tail", 64'(ct_if.rrat_ct_output.tail), 64'd0);
    check("rst_counter", 64'(ct_if.rrat_ct_output.free_list_counter), 64'd32);
    check("rst_fp", 64'(ct_if.rrat_ct_output.free_packet), 64'd0);
    check("rst_squash", 64'(ct_if.rrat_ct_output.squash), 64'd0);
    reset = 1'b0;

    // Single commit: ARN 3 takes PRN 32, old PRN 3 is freed.
    commit(2'b01, 3, 32, 0, 0, 1'b0);
    check("single_entries3", 64'(ct_if.rrat_ct_output.entries[3]), 64'd32);
    check("single_fp0", 64'(ct_if.rrat_ct_output.free_packet[0]), 64'({1'b1, 6'd3}));
    check("single_fp1", 64'(ct_if.rrat_ct_output.free_packet[1].valid), 64'd0);
    check("single_head", 64'(ct_if.rrat_ct_output.head), 64'd1);
    check("single_tail", 64'(ct_if.rrat_ct_output.tail), 64'd1);
    check("single_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd3);
    step();
    check("single_fp_1cycle", 64'(ct_if.rrat_ct_output.free_packet), 64'd0);
    check("single_entries_hold", 64'(ct_if.rrat_ct_output.entries[3]), 64'd32);

    // Same ARN in both slots: second frees the first.
    do_reset();
    commit(2'b11, 3, 32, 3, 33, 1'b0);
    check("same_entries3", 64'(ct_if.rrat_ct_output.entries[3]), 64'd33);
    check("same_fp0", 64'(ct_if.rrat_ct_output.free_packet[0]), 64'({1'b1, 6'd3}));
    check("same_fp1", 64'(ct_if.rrat_ct_output.free_packet[1]), 64'({1'b1, 6'd32}));
    check("same_head", 64'(ct_if.rrat_ct_output.head), 64'd2);
    check("same_tail", 64'(ct_if.rrat_ct_output.tail), 64'd2);
    check("same_fl1", 64'(ct_if.rrat_ct_output.free_list[1]), 64'd32);
    check("same_counter", 64'(ct_if.rrat_ct_output.free_list_counter), 64'd32);

    // Zero register in slot 0 is ignored entirely.
    do_reset();
    commit(2'b11, 0, 40, 7, 32, 1'b0);
    check("zero_entries0", 64'(ct_if.rrat_ct_output.entries[0]), 64'd0);
    check("zero_entries7", 64'(ct_if.rrat_ct_output.entries[7]), 64'd32);
    check("zero_fp0_valid", 64'(ct_if.rrat_ct_output.free_packet[0].valid), 64'd0);
    check("zero_fp1", 64'(ct_if.rrat_ct_output.free_packet[1]), 64'({1'b1, 6'd7}));
    check("zero_head", 64'(ct_if.rrat_ct_output.head), 64'd1);
    check("zero_tail", 64'(ct_if.rrat_ct_output.tail), 64'd1);
    check("zero_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd7);

    // Non-contiguous valid: only slot 1.
    do_reset();
    commit(2'b10, 12, 50, 9, 32, 1'b0);
    check("sparse_entries12", 64'(ct_if.rrat_ct_output.entries[12]), 64'd12);
    check("sparse_entries9", 64'(ct_if.rrat_ct_output.entries[9]), 64'd32);
    check("sparse_fp0_valid", 64'(ct_if.rrat_ct_output.free_packet[0].valid), 64'd0);
    check("sparse_fp1", 64'(ct_if.rrat_ct_output.free_packet[1]), 64'({1'b1, 6'd9}));

    // Squash: snapshot includes the branch slot, free packets suppressed.
    do_reset();
    commit(2'b01, 4, 32, 0, 0, 1'b1);
    check("sq_squash", 64'(ct_if.rrat_ct_output.squash), 64'd1);
    check("sq_entries4", 64'(ct_if.rrat_ct_output.entries[4]), 64'd32);
    check("sq_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd4);
    check("sq_head", 64'(ct_if.rrat_ct_output.head), 64'd1);
    check("sq_fp", 64'(ct_if.rrat_ct_output.free_packet), 64'd0);
    step();
    check("sq_squash_clear", 64'(ct_if.rrat_ct_output.squash), 64'd0);

    // Reset asserted during a commit wins.
    reset = 1'b1;
    commit(2'b01, 5, 33, 0, 0, 1'b1);
    reset = 1'b0;
    check("rstwin_entries5", 64'(ct_if.rrat_ct_output.entries[5]), 64'd5);
    check("rstwin_entries4", 64'(ct_if.rrat_ct_output.entries[4]), 64'd4);
    check("rstwin_head", 64'(ct_if.rrat_ct_output.head), 64'd0);
    check("rstwin_squash", 64'(ct_if.rrat_ct_output.squash), 64'd0);
    check("rstwin_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd32);

    // Wrap: 32 commits pop PRNs 32..63 in ring order; ARNs 1..31 then 1 again.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      commit(2'b11, ((2 * c) % 31) + 1, 32 + 2 * c, ((2 * c + 1) % 31) + 1, 33 + 2 * c, 1'b0);
    end
    check("wrap_head", 64'(ct_if.rrat_ct_output.head), 64'd0);
    check("wrap_tail", 64'(ct_if.rrat_ct_output.tail), 64'd0);
    check("wrap_counter", 64'(ct_if.rrat_ct_output.free_list_counter), 64'd32);
    check("wrap_entries1", 64'(ct_if.rrat_ct_output.entries[1]), 64'd63);
    check("wrap_entries31", 64'(ct_if.rrat_ct_output.entries[31]), 64'd62);
    check("wrap_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd1);
    check("wrap_fl31", 64'(ct_if.rrat_ct_output.free_list[31]), 64'd32);
    check("wrap_fp1", 64'(ct_if.rrat_ct_output.free_packet[1]), 64'({1'b1, 6'd32}));

    // One more commit after wrap pops ring[0], which now holds PRN 1.
    commit(2'b01, 2, 1, 0, 0, 1'b0);
    check("postwrap_entries2", 64'(ct_if.rrat_ct_output.entries[2]), 64'd1);
    check("postwrap_fp0", 64'(ct_if.rrat_ct_output.free_packet[0]), 64'({1'b1, 6'd33}));
    check("postwrap_head", 64'(ct_if.rrat_ct_output.head), 64'd1);
    check("postwrap_fl0", 64'(ct_if.rrat_ct_output.free_list[0]), 64'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
